// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: buffers ALU results in a FIFO and drains one register write per cycle.
// Define WB_FORWARD_EN to enable operand forwarding from buffered entries.
module alu_writeback_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      ALUOut,
  input  logic [4:0]       WriteReg,
  input  logic [5:0]       FuncCode,
  input  logic             WB_STALL,
  output logic             RegWrite,
  output logic [4:0]       WriteRegOut,
  output logic [31:0]      WriteData,
  input  logic [4:0]       ReadReg1,
  input  logic [4:0]       ReadReg2,
  output logic             FWD_HIT_A,
  output logic             FWD_HIT_B,
  output logic [31:0]      FWD_DATA_A,
  output logic [31:0]      FWD_DATA_B,
  output logic [CNT_W-1:0] DROP_CNT
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic ready_q, regw_q;
  logic [4:0] wreg_q;
  logic [31:0] wdata_q;
  logic [31:0] mem_data_q [DEPTH];
  logic [4:0] mem_reg_q [DEPTH];
  logic legal, xfer, push, pop;
  assign legal = FuncCode inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
  assign xfer = IN_VALID && ready_q;
  assign push = xfer && legal;
  // pop looks only at the registered count, so a fresh entry never leaves on its arrival edge
  assign pop = (count_q != '0) && !WB_STALL;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    drop_d = drop_q + CNT_W'(xfer && !legal && !(&drop_q));
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      drop_q <= '0;
      ready_q <= 1'b1;
      regw_q <= 1'b0;
      wreg_q <= '0;
      wdata_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      drop_q <= drop_d;
      ready_q <= count_d != CW'(DEPTH);
      regw_q <= pop;
      wreg_q <= pop ? mem_reg_q[rd_ptr_q] : wreg_q;
      wdata_q <= pop ? mem_data_q[rd_ptr_q] : wdata_q;
    end
  end
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= ALUOut;
      mem_reg_q[wr_ptr_q] <= WriteReg;
    end
  end
  assign IN_READY = ready_q;
  assign RegWrite = regw_q;
  assign WriteRegOut = wreg_q;
  assign WriteData = wdata_q;
  assign DROP_CNT = drop_q;
`ifdef WB_FORWARD_EN
  logic hit_a, hit_b;
  logic [31:0] data_a, data_b;
  // scan oldest to youngest so the youngest match wins
  always_comb begin
    logic [AW-1:0] idx;
    hit_a = 1'b0;
    hit_b = 1'b0;
    data_a = '0;
    data_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + AW'(i);
      if (CW'(i) < count_q && mem_reg_q[idx] == ReadReg1) begin
        hit_a = 1'b1;
        data_a = mem_data_q[idx];
      end
      if (CW'(i) < count_q && mem_reg_q[idx] == ReadReg2) begin
        hit_b = 1'b1;
        data_b = mem_data_q[idx];
      end
    end
  end
  assign FWD_HIT_A = hit_a;
  assign FWD_HIT_B = hit_b;
  assign FWD_DATA_A = data_a;
  assign FWD_DATA_B = data_b;
`else
  logic unused_rd;
  assign unused_rd = ^{ReadReg1, ReadReg2};
  assign FWD_HIT_A = 1'b0;
  assign FWD_HIT_B = 1'b0;
  assign FWD_DATA_A = '0;
  assign FWD_DATA_B = '0;
`endif
endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb_alu_writeback_stage: directed vector table plus hand sequences for stall, forwarding, reset and streaming.
module tb_alu_writeback_stage;
`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 0, in_ready, wb_stall = 0, reg_write, hit_a, hit_b;
  logic [31:0] alu_out = 0, write_data, data_a, data_b;
  logic [4:0] write_reg = 0, write_reg_out, read_reg1 = 0, read_reg2 = 0;
  logic [5:0] func_code = 0;
  logic [7:0] drop_cnt;
  int checks = 0, errors = 0;

  alu_writeback_stage dut (
    .CLK(clk), .RESET(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .ALUOut(alu_out), .WriteReg(write_reg), .FuncCode(func_code), .WB_STALL(wb_stall),
    .RegWrite(reg_write), .WriteRegOut(write_reg_out), .WriteData(write_data),
    .ReadReg1(read_reg1), .ReadReg2(read_reg2), .FWD_HIT_A(hit_a), .FWD_HIT_B(hit_b),
    .FWD_DATA_A(data_a), .FWD_DATA_B(data_b), .DROP_CNT(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [31:0] d; logic [4:0] r; logic [5:0] f; logic s;
    logic e_rw; logic [4:0] e_wr; logic [31:0] e_wd; logic e_rdy; logic [7:0] e_drop;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] r, input logic [5:0] f, input logic s);
    in_valid = v; alu_out = d; write_reg = r; func_code = f; wb_stall = s;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1, 32'h7,  5'd2, 6'd32, 0,  0, 5'd0, 32'h0,  1, 8'd0};
    tbl[1]  = '{0, 32'h0,  5'd0, 6'd0,  0,  1, 5'd2, 32'h7,  1, 8'd0};
    tbl[2]  = '{0, 32'h0,  5'd0, 6'd0,  0,  0, 5'd2, 32'h7,  1, 8'd0};
    tbl[3]  = '{1, 32'h11, 5'd5, 6'd34, 1,  0, 5'd2, 32'h7,  1, 8'd0};
    tbl[4]  = '{1, 32'h22, 5'd6, 6'd36, 1,  0, 5'd2, 32'h7,  0, 8'd0};
    tbl[5]  = '{1, 32'h33, 5'd7, 6'd37, 1,  0, 5'd2, 32'h7,  0, 8'd0};
    tbl[6]  = '{0, 32'h0,  5'd0, 6'd0,  0,  1, 5'd5, 32'h11, 1, 8'd0};
    tbl[7]  = '{0, 32'h0,  5'd0, 6'd0,  0,  1, 5'd6, 32'h22, 1, 8'd0};
    tbl[8]  = '{0, 32'h0,  5'd0, 6'd0,  0,  0, 5'd6, 32'h22, 1, 8'd0};
    tbl[9]  = '{1, 32'h55, 5'd8, 6'h3F, 0,  0, 5'd6, 32'h22, 1, 8'd1};
    tbl[10] = '{0, 32'h0,  5'd0, 6'd0,  0,  0, 5'd6, 32'h22, 1, 8'd1};
    tbl[11] = '{1, 32'h1,  5'd1, 6'd39, 1,  0, 5'd6, 32'h22, 1, 8'd1};
    tbl[12] = '{1, 32'h2,  5'd2, 6'd42, 1,  0, 5'd6, 32'h22, 0, 8'd1};
    tbl[13] = '{1, 32'h3,  5'd3, 6'd32, 0,  1, 5'd1, 32'h1,  1, 8'd1};
    tbl[14] = '{0, 32'h0,  5'd0, 6'd0,  0,  1, 5'd2, 32'h2,  1, 8'd1};
    tbl[15] = '{0, 32'h0,  5'd0, 6'd0,  0,  0, 5'd2, 32'h2,  1, 8'd1};

    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_regwrite", reg_write, 0);
    chk("rst_wreg", write_reg_out, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_hit_a", hit_a, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f, tbl[i].s);
      step();
      chk($sformatf("vec%0d_regwrite", i), reg_write, tbl[i].e_rw);
      chk($sformatf("vec%0d_wreg", i), write_reg_out, tbl[i].e_wr);
      chk($sformatf("vec%0d_wdata", i), write_data, tbl[i].e_wd);
      chk($sformatf("vec%0d_ready", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_drop", i), drop_cnt, tbl[i].e_drop);
    end

    drive(1, 32'hA, 5'd9, 6'd32, 1);
    step();
    read_reg1 = 5'd9; read_reg2 = 5'd3;
    #1;
    chk("fwd_one_hit_a", hit_a, FWD ? 1 : 0);
    chk("fwd_one_data_a", data_a, FWD ? 32'hA : 0);
    drive(1, 32'hB, 5'd9, 6'd32, 1);
    step();
    chk("fwd_two_hit_a", hit_a, FWD ? 1 : 0);
    chk("fwd_two_data_a", data_a, FWD ? 32'hB : 0);
    chk("fwd_two_hit_b", hit_b, 0);
    chk("fwd_two_data_b", data_b, 0);
    chk("full_ready", in_ready, 0);
    drive(0, 0, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", in_ready, 1);
    chk("async_rst_regwrite", reg_write, 0);
    chk("async_rst_drop", drop_cnt, 0);
    chk("async_rst_hit_a", hit_a, 0);
    chk("async_rst_data_a", data_a, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst%0d_regwrite", i), reg_write, 0);
    end

    drive(1, 32'h77, 5'd4, 6'd32, 0);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    chk("strobe_regwrite", reg_write, 1);
    chk("strobe_wdata", write_data, 32'h77);
    #2 rst_n = 1'b0;
    #1;
    chk("strobe_rst_regwrite", reg_write, 0);
    chk("strobe_rst_wreg", write_reg_out, 0);
    chk("strobe_rst_wdata", write_data, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("strobe_post%0d_regwrite", i), reg_write, 0);
    end

    drive(1, 32'h5, 5'd1, 6'h3F, 0);
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 0) chk("drop_first", drop_cnt, 1);
    end
    chk("drop_saturate", drop_cnt, 8'd255);
    chk("drop_no_write", reg_write, 0);

    for (int k = 0; k <= 10; k++) begin
      drive(k < 10, 32'h100 + k, 5'(k + 1), 6'd32, 0);
      step();
      chk($sformatf("stream%0d_ready", k), in_ready, 1);
      chk($sformatf("stream%0d_regwrite", k), reg_write, k >= 1);
      if (k >= 1) begin
        chk($sformatf("stream%0d_wreg", k), write_reg_out, 5'(k));
        chk($sformatf("stream%0d_wdata", k), write_data, 32'h100 + k - 1);
      end
    end
    drive(0, 0, 0, 0, 0);
    step();
    chk("stream_end_regwrite", reg_write, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
